// File: rtl/dot_product_engine_pkg.sv
// Shared definitions for the dot-product engine: FSM states and a width helper.
package dot_product_engine_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Bits needed to hold values 0..value-1.
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned width;
      width = 0;
      while ((32'd1 << width) < value) width++;
      return width;
   endfunction

endpackage

// File: rtl/dot_product_engine_mac_stage.sv
// Registered multiplier followed by an accumulator with wrap/saturate and sticky overflow.
module mac_stage #(
   parameter int DATA_W   = 4,
   parameter int ACC_W    = 12,
   parameter int SIGNED   = 0,
   parameter int SATURATE = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              load,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic [ACC_W-1:0]  acc,
   output logic              ovf
);

   localparam int PROD_W = 2 * DATA_W;

   logic              a_ext, b_ext, p_ext, acc_ext;
   logic [PROD_W-1:0] product, prod;
   logic              prod_vld;
   logic [ACC_W:0]    sum;
   logic              sum_ovf;
   logic [ACC_W-1:0]  acc_n;

   assign a_ext   = (SIGNED != 0) & a[DATA_W-1];
   assign b_ext   = (SIGNED != 0) & b[DATA_W-1];
   assign p_ext   = (SIGNED != 0) & prod[PROD_W-1];
   assign acc_ext = (SIGNED != 0) & acc[ACC_W-1];

   // Operands extended to full product width so the low half is the exact product either way.
   assign product = {{DATA_W{a_ext}}, a} * {{DATA_W{b_ext}}, b};
   assign sum     = {acc_ext, acc} + {{(ACC_W + 1 - PROD_W){p_ext}}, prod};

   always_comb begin
      sum_ovf = (SIGNED != 0) ? (sum[ACC_W] != sum[ACC_W-1]) : sum[ACC_W];
      acc_n   = sum[ACC_W-1:0];
      if (sum_ovf && (SATURATE != 0)) begin
         if (SIGNED != 0)
            acc_n = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
         else
            acc_n = '1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst || clear) begin
         prod_vld <= 1'b0;
         prod     <= '0;
         acc      <= '0;
         ovf      <= 1'b0;
      end else begin
         prod_vld <= load;
         if (load) prod <= product;
         if (prod_vld) begin
            acc <= acc_n;
            ovf <= ovf | sum_ovf;
         end
      end
   end

endmodule

// File: rtl/dot_product_engine.sv
// Dot-product engine: start/done handshake, fixed-length term count, result/overflow registers.
module dot_product_engine
   import dot_product_engine_pkg::*;
#(
   parameter int DATA_W   = 4,
   parameter int ACC_W    = 12,
   parameter int VEC_LEN  = 8,
   parameter int SIGNED   = 0,
   parameter int SATURATE = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              enable,
   input  logic [DATA_W-1:0] ram_out,
   input  logic [DATA_W-1:0] rom_out,
   output logic              busy,
   output logic              done,
   output logic [ACC_W-1:0]  result,
   output logic              overflow
);

   localparam int unsigned    CNT_W    = clog2(VEC_LEN + 1);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(VEC_LEN - 1);

   state_t           state, state_n;
   logic             clear, accept, finish, capture;
   logic [CNT_W-1:0] count;
   logic [ACC_W-1:0] acc;
   logic             acc_ovf;

   always_ff @(posedge clk) begin
      if (!rst) state <= IDLE;
      else      state <= state_n;
   end

   always_comb begin
      state_n = state;
      clear   = 1'b0;
      accept  = 1'b0;
      finish  = 1'b0;
      case (state)
         IDLE, DONE: begin
            if (start) begin
               state_n = ACCUM;
               clear   = 1'b1;
            end
         end
         ACCUM: begin
            if (start) begin
               clear = 1'b1;
            end else if (enable) begin
               accept = 1'b1;
               if (count == LAST_IDX) state_n = DRAIN;
            end
         end
         DRAIN: begin
            if (start) begin
               state_n = ACCUM;
               clear   = 1'b1;
            end else begin
               state_n = DONE;
               finish  = 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // Capture lags DRAIN by one edge so the final product has landed in acc.
   always_ff @(posedge clk) begin
      if (!rst) begin
         count    <= '0;
         capture  <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         result   <= '0;
         overflow <= 1'b0;
      end else begin
         capture <= finish;
         done    <= capture;
         if (capture) begin
            result   <= acc;
            overflow <= acc_ovf;
         end
         if (clear)       count <= '0;
         else if (accept) count <= count + 1'b1;
         if (clear)        busy <= 1'b1;
         else if (capture) busy <= 1'b0;
      end
   end

   mac_stage #(
      .DATA_W  (DATA_W),
      .ACC_W   (ACC_W),
      .SIGNED  (SIGNED),
      .SATURATE(SATURATE)
   ) u_mac (
      .clk  (clk),
      .rst  (rst),
      .clear(clear),
      .load (accept),
      .a    (ram_out),
      .b    (rom_out),
      .acc  (acc),
      .ovf  (acc_ovf)
   );

endmodule

// File: tb/tb_dot_product_engine.sv
// Multi-configuration bench: directed vectors plus randomized traffic against a transaction-level model.
module tb_dot_product_engine;

   localparam int N = 6;
   localparam int CFG_AW [N] = '{12, 8, 8, 12, 12, 8};
   localparam int CFG_VL [N] = '{7, 4, 4, 2, 8, 6};
   localparam int CFG_SG [N] = '{0, 0, 0, 1, 0, 1};
   localparam int CFG_SA [N] = '{0, 1, 0, 0, 0, 1};

   localparam logic [3:0] PA [7] = '{4'h1, 4'h3, 4'hA, 4'h5, 4'h4, 4'h3, 4'h0};
   localparam logic [3:0] PB [7] = '{4'h9, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7};

   logic         clk = 1'b0;
   logic [N-1:0] rs, st, en, busy_w, done_w, ovf_w;
   logic [3:0]   ra [N];
   logic [3:0]   ro [N];
   logic [11:0]  res_w [N];

   int errors = 0, checks = 0, cyc_n = 0, printed = 0;
   int done_at [N];
   int done_cnt [N];

   // Model: one in-flight vector per instance, completed result due two edges after the last pair.
   bit     m_active [N];
   int     m_cnt    [N];
   longint m_sum    [N];
   bit     m_ovf    [N];
   int     m_pend   [N];
   longint m_pres   [N];
   bit     m_povf   [N];
   longint m_res    [N];
   bit     m_ovfo   [N];
   bit     m_busy   [N];
   bit     m_done   [N];

   initial forever #5 clk = ~clk;

   for (genvar g = 0; g < N; g++) begin : gen_dut
      localparam int AW = CFG_AW[g];
      logic [AW-1:0] r;
      dot_product_engine #(
         .DATA_W  (4),
         .ACC_W   (AW),
         .VEC_LEN (CFG_VL[g]),
         .SIGNED  (CFG_SG[g]),
         .SATURATE(CFG_SA[g])
      ) u_dut (
         .clk     (clk),
         .rst     (rs[g]),
         .start   (st[g]),
         .enable  (en[g]),
         .ram_out (ra[g]),
         .rom_out (ro[g]),
         .busy    (busy_w[g]),
         .done    (done_w[g]),
         .result  (r),
         .overflow(ovf_w[g])
      );
      assign res_w[g] = 12'(r);
   end

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         if (printed < 40) $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc_n);
         printed++;
      end
   endtask

   function automatic longint sval(input logic [3:0] v, input int sg);
      return (sg != 0 && v[3]) ? longint'(v) - 16 : longint'(v);
   endfunction

   task automatic model_step(input int i);
      longint t, hi, lo, span;
      if (!rs[i]) begin
         m_active[i] = 0; m_pend[i] = 0; m_res[i] = 0; m_ovfo[i] = 0;
         m_busy[i] = 0; m_done[i] = 0;
         return;
      end
      m_done[i] = 0;
      if (m_pend[i] > 0) begin
         m_pend[i]--;
         if (m_pend[i] == 0) begin
            m_res[i] = m_pres[i]; m_ovfo[i] = m_povf[i]; m_done[i] = 1; m_busy[i] = 0;
         end
      end
      if (st[i]) begin
         if (m_pend[i] == 1) m_pend[i] = 0;
         m_active[i] = 1; m_cnt[i] = 0; m_sum[i] = 0; m_ovf[i] = 0; m_busy[i] = 1;
      end else if (m_active[i] && en[i]) begin
         span = longint'(1) << CFG_AW[i];
         hi   = (CFG_SG[i] != 0) ? span / 2 - 1 : span - 1;
         lo   = (CFG_SG[i] != 0) ? -(span / 2) : 0;
         t    = m_sum[i] + sval(ra[i], CFG_SG[i]) * sval(ro[i], CFG_SG[i]);
         if (t > hi || t < lo) begin
            m_ovf[i] = 1;
            if (CFG_SA[i] != 0) t = (t > hi) ? hi : lo;
            else begin
               t = t & (span - 1);
               if (t > hi) t = t - span;
            end
         end
         m_sum[i] = t;
         m_cnt[i]++;
         if (m_cnt[i] == CFG_VL[i]) begin
            m_active[i] = 0; m_pend[i] = 2; m_pres[i] = m_sum[i]; m_povf[i] = m_ovf[i];
         end
      end
   endtask

   task automatic compare();
      for (int i = 0; i < N; i++) begin
         chk($sformatf("busy[%0d]", i), longint'(busy_w[i]), longint'(m_busy[i]));
         chk($sformatf("done[%0d]", i), longint'(done_w[i]), longint'(m_done[i]));
         chk($sformatf("overflow[%0d]", i), longint'(ovf_w[i]), longint'(m_ovfo[i]));
         chk($sformatf("result[%0d]", i), longint'(res_w[i]),
             m_res[i] & ((longint'(1) << CFG_AW[i]) - 1));
         if (done_w[i]) begin
            done_at[i] = cyc_n;
            done_cnt[i]++;
         end
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      cyc_n++;
      for (int i = 0; i < N; i++) model_step(i);
      @(negedge clk);
      compare();
   endtask

   task automatic feed(input int i, input logic [3:0] a, input logic [3:0] b);
      en[i] = 1'b1; ra[i] = a; ro[i] = b;
      cyc();
      en[i] = 1'b0;
   endtask

   task automatic pulse_start(input int i, output int t0);
      st[i] = 1'b1;
      cyc();
      st[i] = 1'b0;
      t0 = cyc_n;
   endtask

   task automatic wait_done(input int i);
      int n = 0;
      while (!done_w[i] && n < 40) begin
         cyc();
         n++;
      end
      chk($sformatf("done_seen[%0d]", i), longint'(done_w[i]), 1);
   endtask

   function automatic logic [3:0] pick();
      case ($urandom_range(0, 4))
         0: return 4'h0;
         1: return 4'h7;
         2: return 4'h8;
         3: return 4'hF;
         default: return 4'($urandom);
      endcase
   endfunction

   initial begin
      int t0, dc;
      rs = '0; st = '0; en = '0;
      for (int i = 0; i < N; i++) begin
         ra[i] = '0; ro[i] = '0; done_at[i] = 0; done_cnt[i] = 0;
      end
      cyc(); cyc();
      chk("reset_busy", longint'(busy_w[0]), 0);
      chk("reset_result", longint'(res_w[0]), 0);
      rs = '1;
      cyc();

      // Basic vector
      pulse_start(0, t0);
      for (int k = 0; k < 7; k++) feed(0, PA[k], PB[k]);
      wait_done(0);
      chk("t1_latency", done_at[0] - t0, 9);
      chk("t1_result", longint'(res_w[0]), 64'h067);
      chk("t1_model", m_res[0], 103);
      chk("t1_overflow", longint'(ovf_w[0]), 0);
      cyc();

      // Same vector with a 3-cycle bubble
      pulse_start(0, t0);
      for (int k = 0; k < 7; k++) begin
         feed(0, PA[k], PB[k]);
         if (k == 2) begin
            cyc(); cyc(); cyc();
            chk("t2_busy_bubble", longint'(busy_w[0]), 1);
         end
      end
      wait_done(0);
      chk("t2_latency", done_at[0] - t0, 12);
      chk("t2_result", longint'(res_w[0]), 64'h067);

      // Saturate vs wrap on 8-bit accumulators
      st[1] = 1'b1; st[2] = 1'b1;
      cyc();
      st[1] = 1'b0; st[2] = 1'b0;
      for (int k = 0; k < 4; k++) begin
         en[1] = 1'b1; en[2] = 1'b1;
         ra[1] = 4'hF; ro[1] = 4'hF; ra[2] = 4'hF; ro[2] = 4'hF;
         cyc();
      end
      en[1] = 1'b0; en[2] = 1'b0;
      wait_done(1);
      chk("t3_sat_result", longint'(res_w[1]), 64'hFF);
      chk("t3_sat_overflow", longint'(ovf_w[1]), 1);
      chk("t3_wrap_result", longint'(res_w[2]), 64'h84);
      chk("t3_wrap_overflow", longint'(ovf_w[2]), 1);

      // Signed products
      pulse_start(3, t0);
      feed(3, 4'h8, 4'h7);
      feed(3, 4'h3, 4'hE);
      wait_done(3);
      chk("t4_result", longint'(res_w[3]), 64'hFC2);
      chk("t4_model", m_res[3], -62);
      chk("t4_overflow", longint'(ovf_w[3]), 0);

      // Reset mid-vector
      pulse_start(0, t0);
      for (int k = 0; k < 3; k++) feed(0, PA[k], PB[k]);
      dc = done_cnt[0];
      rs[0] = 1'b0;
      cyc();
      rs[0] = 1'b1;
      chk("t5_busy", longint'(busy_w[0]), 0);
      chk("t5_result", longint'(res_w[0]), 0);
      cyc(); cyc(); cyc();
      chk("t5_no_done", done_cnt[0] - dc, 0);
      pulse_start(0, t0);
      for (int k = 0; k < 7; k++) feed(0, PA[k], PB[k]);
      wait_done(0);
      chk("t5_after_result", longint'(res_w[0]), 64'h067);

      // Restart after 4 pairs
      dc = done_cnt[4];
      pulse_start(4, t0);
      for (int k = 0; k < 4; k++) feed(4, 4'h1, 4'h1);
      pulse_start(4, t0);
      for (int k = 0; k < 8; k++) feed(4, 4'h1, 4'h1);
      wait_done(4);
      cyc(); cyc(); cyc(); cyc();
      chk("t6_done_pulses", done_cnt[4] - dc, 1);
      chk("t6_result", longint'(res_w[4]), 64'h008);

      // Randomized traffic on all instances
      for (int c = 0; c < 4000; c++) begin
         for (int i = 0; i < N; i++) begin
            rs[i] = ($urandom_range(0, 499) != 0);
            st[i] = ($urandom_range(0, 29) == 0);
            en[i] = ($urandom_range(0, 3) != 0);
            ra[i] = pick();
            ro[i] = pick();
         end
         cyc();
      end
      rs = '1; st = '0; en = '0;
      for (int c = 0; c < 5; c++) cyc();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
